// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// width constants used by the top level and the testbench.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int PKT_COUNT_WIDTH    = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: selects the first requester at or after
// last_grant+1 (modulo NUM_REQ) whose mask bit is set.
module rr_priority_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_mask,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         winner,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    // Walk the requesters starting just after the previous winner; the
    // first set bit found wins and blocks all later candidates.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any && req_mask[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one buffered UART transmitter between
// several byte producers; the grant is held for a whole packet.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          tx_busy,
    output logic [DATA_WIDTH-1:0]         tx_data_in,
    output logic                          tx_start_transmission,
    output logic                          idle,
    output logic [PKT_COUNT_WIDTH-1:0]    packet_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t       state;
    logic [IDX_W-1:0] last_grant;
    logic             last_pending;
    logic [GAP_W-1:0] gap_cnt;

    logic [NUM_REQ-1:0]    winner;
    logic                  any_req;
    logic [IDX_W-1:0]      winner_idx;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] owner_byte;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_mask   (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any        (any_req)
    );

    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                winner_idx = IDX_W'(i);
            end
        end
    end

    // While a packet is in flight last_grant is also the owner's index.
    assign owner_byte = req_data[last_grant*DATA_WIDTH +: DATA_WIDTH];
    assign transfer   = (state == SEND) && req_valid[last_grant] && !tx_busy;
    assign req_ready  = ((state == SEND) && !tx_busy) ? grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            grant                 <= '0;
            last_grant            <= IDX_W'(NUM_REQ - 1);
            last_pending          <= 1'b0;
            gap_cnt               <= '0;
            tx_data_in            <= '0;
            tx_start_transmission <= 1'b0;
            idle                  <= 1'b1;
            packet_count          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= winner;
                        last_grant <= winner_idx;
                        idle       <= 1'b0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (transfer) begin
                        tx_data_in            <= owner_byte;
                        tx_start_transmission <= ~tx_start_transmission;
                        last_pending          <= req_last[last_grant];
                        gap_cnt               <= GAP_W'(GAP_CYCLES - 1);
                        state                 <= GAP;
                    end
                end
                GAP: begin
                    // The core's busy flag lags a new byte, so it is only
                    // trusted again once the gap has fully elapsed.
                    if (gap_cnt == '0) begin
                        if (last_pending) begin
                            grant        <= '0;
                            packet_count <= packet_count + PKT_COUNT_WIDTH'(1);
                            idle         <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: reset/arbitration vector table,
// directed multi-cycle sequences and randomized packets against a queue model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int GAP_CYCLES = 2;
    localparam int DEPTH      = 64;

    logic                          clk;
    logic                          reset;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          tx_busy;
    logic [DATA_WIDTH-1:0]         tx_data_in;
    logic                          tx_start_transmission;
    logic                          idle;
    logic [15:0]                   packet_count;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .req_valid             (req_valid),
        .req_data              (req_data),
        .req_last              (req_last),
        .req_ready             (req_ready),
        .grant                 (grant),
        .tx_busy               (tx_busy),
        .tx_data_in            (tx_data_in),
        .tx_start_transmission (tx_start_transmission),
        .idle                  (idle),
        .packet_count          (packet_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle;
    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic               busy;
        logic [NUM_REQ-1:0] exp_grant;
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_idle;
    } vec_t;

    vec_t vecs [6];

    int checks = 0;
    int errors = 0;

    // Per-requester byte streams {last, data}, consumed on each handshake.
    logic [8:0]  pkt_mem [NUM_REQ][DEPTH];
    int          wr_ptr  [NUM_REQ];
    int          rd_ptr  [NUM_REQ];
    logic [15:0] exp_q [$];
    int          exp_packets;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic doReset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_ptr[i] = 0;
            rd_ptr[i] = 0;
        end
        exp_q.delete();
        exp_packets = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic addByte(input int r, input logic [7:0] data, input logic last);
        pkt_mem[r][wr_ptr[r]] = {last, data};
        wr_ptr[r]++;
    endtask

    function automatic bit allEmpty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_ptr[i] < wr_ptr[i]) e = 1'b0;
        end
        return e;
    endfunction

    // Reference order: starting after requester NUM_REQ-1, repeatedly serve
    // one whole packet from the next requester (cyclically) with data left.
    task automatic buildExpected();
        int  ptr [NUM_REQ];
        int  owner;
        int  r;
        bit  found;
        bit  done;
        for (int i = 0; i < NUM_REQ; i++) ptr[i] = rd_ptr[i];
        owner = NUM_REQ - 1;
        exp_q.delete();
        exp_packets = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                r = (owner + k) % NUM_REQ;
                if (!found && ptr[r] < wr_ptr[r]) begin
                    done = 1'b0;
                    while (!done && ptr[r] < wr_ptr[r]) begin
                        exp_q.push_back({8'(r), pkt_mem[r][ptr[r]][7:0]});
                        done = pkt_mem[r][ptr[r]][8];
                        ptr[r]++;
                    end
                    exp_packets++;
                    owner = r;
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic driveInputs(input bit random_busy);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_ptr[i] < wr_ptr[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DATA_WIDTH +: DATA_WIDTH] = pkt_mem[i][rd_ptr[i]][7:0];
                req_last[i] = pkt_mem[i][rd_ptr[i]][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DATA_WIDTH +: DATA_WIDTH] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
        tx_busy = random_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    // Streams all loaded packets through the DUT, checking each issued byte
    // against the handshake one cycle earlier and against the model order.
    task automatic runEngine(input int max_cycles, input bit random_busy, input bit check_spacing);
        logic               model_tog;
        logic [NUM_REQ-1:0] acc_prev;
        logic [7:0]         acc_data;
        bit                 acc_last;
        logic [15:0]        e;
        int                 last_tog_cycle;
        bit                 have_tog;
        bit                 prev_last;
        bit                 done;
        int                 n;
        model_tog = 1'b0; acc_prev = '0; acc_data = '0; acc_last = 1'b0;
        last_tog_cycle = 0; have_tog = 1'b0; prev_last = 1'b0; done = 1'b0; n = 0;
        while (!done && n < max_cycles) begin
            @(negedge clk);
            n++;
            if (|acc_prev) model_tog = ~model_tog;
            checkOutput("start_toggle", 32'(tx_start_transmission), 32'(model_tog));
            checkOutput("ready_outside_grant", 32'(req_ready & ~grant), 0);
            if (|acc_prev) begin
                checkOutput("issued_byte", 32'(tx_data_in), 32'(acc_data));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_byte: got 0x%0h, expected no further byte", tx_data_in);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("order_data", 32'(tx_data_in), 32'(e[7:0]));
                    checkOutput("order_grant", 32'(grant), 32'(1) << e[15:8]);
                end
                if (check_spacing && have_tog)
                    checkOutput("byte_spacing", 32'(cycle - last_tog_cycle),
                                prev_last ? 32'(GAP_CYCLES + 2) : 32'(GAP_CYCLES + 1));
                have_tog       = 1'b1;
                last_tog_cycle = cycle;
                prev_last      = acc_last;
            end
            if (allEmpty() && exp_q.size() == 0) done = 1'b1;
            driveInputs(random_busy);
            #1;
            acc_prev = req_valid & req_ready;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_prev[i]) begin
                    acc_data = pkt_mem[i][rd_ptr[i]][7:0];
                    acc_last = pkt_mem[i][rd_ptr[i]][8];
                end
            end
            @(posedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_prev[i]) rd_ptr[i]++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL engine_timeout: got %0d bytes outstanding, expected 0", exp_q.size());
        end
        tx_busy = 1'b0;
        repeat (GAP_CYCLES + 2) @(negedge clk);
        checkOutput("end_idle", 32'(idle), 1);
        checkOutput("end_grant", 32'(grant), 0);
        checkOutput("end_toggle", 32'(tx_start_transmission), 32'(model_tog));
        checkOutput("end_packet_count", 32'(packet_count), 32'(exp_packets));
    endtask

    // One arbitration step from reset: apply a valid mask and busy level,
    // then inspect grant, ready and idle one edge later.
    task automatic applyStimulus(input vec_t v, input int idx);
        doReset();
        req_valid = v.valid;
        req_data  = {NUM_REQ{8'hA5}};
        req_last  = '1;
        tx_busy   = v.busy;
        @(posedge clk);
        @(negedge clk);
        checkOutput($sformatf("vec%0d_grant", idx), 32'(grant), 32'(v.exp_grant));
        checkOutput($sformatf("vec%0d_ready", idx), 32'(req_ready), 32'(v.exp_ready));
        checkOutput($sformatf("vec%0d_idle", idx), 32'(idle), 32'(v.exp_idle));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b0};
        vecs[1] = '{4'b0110, 1'b0, 4'b0010, 4'b0010, 1'b0};
        vecs[2] = '{4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b0};
        vecs[3] = '{4'b1100, 1'b1, 4'b0100, 4'b0000, 1'b0};
        vecs[4] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
        vecs[5] = '{4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0};

        // Reset values and quiet idling.
        doReset();
        checkOutput("reset_grant", 32'(grant), 0);
        checkOutput("reset_ready", 32'(req_ready), 0);
        checkOutput("reset_data", 32'(tx_data_in), 0);
        checkOutput("reset_start", 32'(tx_start_transmission), 0);
        checkOutput("reset_idle", 32'(idle), 1);
        checkOutput("reset_count", 32'(packet_count), 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("quiet_idle", 32'(idle), 1);
            checkOutput("quiet_start", 32'(tx_start_transmission), 0);
        end

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // Reset after the first byte of a three-byte packet.
        doReset();
        req_valid = 4'b0001;
        req_data  = {24'h0, 8'h11};
        req_last  = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_ready", 32'(req_ready), 32'(4'b0001));
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_start", 32'(tx_start_transmission), 1);
        checkOutput("midrst_data", 32'(tx_data_in), 32'h11);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_grant", 32'(grant), 0);
        checkOutput("midrst_idle", 32'(idle), 1);
        checkOutput("midrst_count", 32'(packet_count), 0);
        checkOutput("midrst_toggle", 32'(tx_start_transmission), 0);
        checkOutput("midrst_data0", 32'(tx_data_in), 0);
        reset     = 1'b0;
        req_valid = '0;

        // Single owner, two-byte packet from requester 2.
        doReset();
        addByte(2, 8'h0A, 1'b0);
        addByte(2, 8'h0D, 1'b1);
        buildExpected();
        runEngine(100, 1'b0, 1'b1);

        // Contention between requesters 0 and 1, three bytes each.
        doReset();
        for (int b = 0; b < 3; b++) begin
            addByte(0, 8'(8'h01 + b), 1'(b == 2));
            addByte(1, 8'(8'h11 + b), 1'(b == 2));
        end
        buildExpected();
        runEngine(200, 1'b0, 1'b1);

        // Fairness: requesters 0 and 3 each queue two packets.
        doReset();
        for (int p = 0; p < 2; p++) begin
            addByte(0, 8'(8'h40 + p), 1'b0);
            addByte(0, 8'(8'h50 + p), 1'b1);
            addByte(3, 8'(8'hC0 + p), 1'b0);
            addByte(3, 8'(8'hD0 + p), 1'b1);
        end
        buildExpected();
        runEngine(300, 1'b0, 1'b1);

        // Backpressure: busy held for 50 cycles while requester 1 owns SEND.
        doReset();
        req_valid = 4'b0010;
        req_data  = {16'h0, 8'h55, 8'h0};
        req_last  = 4'b0010;
        tx_busy   = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkOutput("bp_ready", 32'(req_ready), 0);
            checkOutput("bp_start", 32'(tx_start_transmission), 0);
        end
        checkOutput("bp_grant", 32'(grant), 32'(4'b0010));
        tx_busy = 1'b0;
        #1;
        checkOutput("bp_ready_release", 32'(req_ready), 32'(4'b0010));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        checkOutput("bp_start_issue", 32'(tx_start_transmission), 1);
        checkOutput("bp_data", 32'(tx_data_in), 32'h55);
        repeat (GAP_CYCLES + 2) @(negedge clk);
        checkOutput("bp_idle", 32'(idle), 1);
        checkOutput("bp_count", 32'(packet_count), 1);

        // Randomized packets; odd rounds add random backpressure.
        for (int round = 0; round < 6; round++) begin
            doReset();
            for (int r = 0; r < NUM_REQ; r++) begin
                int npkt;
                int len;
                npkt = $urandom_range(0, 3);
                for (int p = 0; p < npkt; p++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) addByte(r, 8'($urandom), 1'(b == len - 1));
                end
            end
            buildExpected();
            runEngine(2000, 1'(round % 2), 1'(round % 2 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
